cy8_serial_adder: RTL and testbench
===================================

CY8_SERIAL_ADDER -- requirements
Module: cy8_serial_adder

Interface
REQ-001 Parameter NUM_WORDS, default 4, is the number of 8-bit words per operation; the legal range is 1..256.
REQ-002 CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  is the reset: synchronous, active-high.
REQ-004 START  input  1  is a one-cycle request to begin an operation; it is sampled only in IDLE.
REQ-005 SUB  input  1  selects the operation when START is accepted: 0 = A+B, 1 = A-B.
REQ-006 A_IN  input  8  is the operand A word, least-significant word first.
REQ-007 B_IN  input  8  is the operand B word, least-significant word first.
REQ-008 IN_VALID  input  1  qualifies A_IN and B_IN.
REQ-009 IN_READY  output  1  indicates the block accepts an operand word this cycle.
REQ-010 SUM_OUT  output  8  is the registered result word.
REQ-011 OUT_VALID  output  1  qualifies SUM_OUT.
REQ-012 OUT_READY  input  1  is the downstream acceptance of SUM_OUT.
REQ-013 OUT_LAST  output  1  marks the final result word of an operation; it is valid with OUT_VALID.
REQ-014 CO_OUT  output  1  is the carry out of bit 7 of the last word; it is valid with OUT_LAST.
REQ-015 OV_OUT  output  1  is the signed overflow of the full-width result; it is valid with OUT_LAST.
REQ-016 BUSY  output  1  is high in every state other than IDLE.

Function
REQ-017 States: IDLE, RUN, DRAIN; encoding is free.
REQ-018 IDLE->RUN on START=1: latch SUB, set carry register C=SUB, clear word counter.
REQ-019 An operand word is accepted on a cycle where IN_READY=1 and IN_VALID=1; IN_READY = (state==RUN) and (OUT_VALID=0 or OUT_READY=1).
REQ-020 Per accepted word, the block computes the carry-chain function on that word:
  - Bp = B_IN xor {8{SUB}}.
  - Propagate S = A_IN xor Bp; generate DI = A_IN.
  - Stage carry: c[i+1] = S[i] ? c[i] : DI[i], with c[0] = C.
  - Sum bit O[i] = S[i] xor c[i].
REQ-021 On the acceptance edge: SUM_OUT <= O; C <= c[8]; OUT_VALID <= 1; latency is exactly 1 cycle from acceptance to OUT_VALID.
REQ-022 The word counter increments per accepted word; on the acceptance of word NUM_WORDS-1 the block sets OUT_LAST<=1, CO_OUT<=c[8], OV_OUT<=c[7] xor c[8], and the state goes RUN->DRAIN.
REQ-023 A result transfers when OUT_VALID=1 and OUT_READY=1. OUT_VALID clears on transfer unless a new word is accepted in the same cycle, in which case it stays 1 with the new SUM_OUT.
REQ-024 DRAIN->IDLE on transfer of the OUT_LAST word; OUT_LAST, CO_OUT and OV_OUT clear on that transfer.
REQ-025 SUM_OUT, OUT_LAST, CO_OUT and OV_OUT hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 START is ignored in RUN and DRAIN; SUB is sampled only at START acceptance.
REQ-027 Carry convention: CO_OUT=1 on subtract means no borrow (A>=B unsigned).
REQ-028 With NUM_WORDS=1, the first accepted word is also the last: RUN->DRAIN after one acceptance.
REQ-029 Operand words presented with IN_VALID=1 in IDLE or DRAIN are not consumed (IN_READY=0).

Reset
REQ-030 RST=1 at a rising edge forces: state=IDLE, C=0, counter=0, OUT_VALID=0, OUT_LAST=0, CO_OUT=0, OV_OUT=0, SUM_OUT=0x00, BUSY=0, IN_READY=0.
REQ-031 RST has priority over all other inputs, including mid-operation; no partial result is presented after reset.

Verification
REQ-032 NUM_WORDS=4, SUB=0, A=0xFFFFFFFF, B=0x00000001, OUT_READY=1 -> SUM_OUT words 00,00,00,00; OUT_LAST on the 4th word; CO_OUT=1, OV_OUT=0.
REQ-033 NUM_WORDS=4, SUB=1, A=0x00000000, B=0x00000001 -> words FF,FF,FF,FF; CO_OUT=0 (borrow), OV_OUT=0.
REQ-034 NUM_WORDS=4, SUB=0, A=0x7FFFFFFF, B=0x00000001 -> words 00,00,00,80; CO_OUT=0, OV_OUT=1.
REQ-035 OUT_READY=0 for 3 cycles after the 1st result -> IN_READY=0 and SUM_OUT stable during the stall; no word is lost or duplicated; the final result is unchanged vs REQ-032.
REQ-036 RST=1 asserted after the 2nd accepted word -> next cycle all outputs at reset values and BUSY=0; a new START runs a fresh operation with correct results.
REQ-037 NUM_WORDS=1, SUB=1, A=0x05, B=0x03 -> SUM_OUT=0x02, OUT_LAST=1, CO_OUT=1; START asserted during DRAIN is ignored.

Source files
------------

// File: rtl/cy8_serial_adder.sv
// Word-serial multi-word adder/subtractor: one 8-bit carry-chain slice per accepted
// operand word, LS word first, with a ready/valid result stream and final flags.
module cy8_serial_adder #(
    parameter int NUM_WORDS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SUB,
    input  logic [7:0] A_IN,
    input  logic [7:0] B_IN,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] SUM_OUT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_LAST,
    output logic       CO_OUT,
    output logic       OV_OUT,
    output logic       BUSY
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic                r_sub;
    logic                r_c;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_sum;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_co;
    logic                r_ov;

    logic [DATA_W-1:0]   w_bp;
    logic [DATA_W+1:0]   w_chain;
    logic                w_accept;
    logic                w_xfer;
    logic                w_last_word;

    // Returns {c[8], c[7], sum[7:0]}; generate comes from A since S=0 means A==Bp.
    function automatic logic [DATA_W+1:0] carry_chain(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] bp,
        input logic              cin
    );
        logic [DATA_W:0]   c;
        logic [DATA_W-1:0] s;
        s    = a ^ bp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DATA_W; i++) begin
            c[i+1] = s[i] ? c[i] : a[i];
        end
        return {c[DATA_W], c[DATA_W-1], s ^ c[DATA_W-1:0]};
    endfunction

    assign w_bp        = B_IN ^ {DATA_W{r_sub}};
    assign w_chain     = carry_chain(A_IN, w_bp, r_c);
    assign IN_READY    = (r_state == S_RUN) && (!r_out_valid || OUT_READY);
    assign w_accept    = IN_READY && IN_VALID;
    assign w_xfer      = r_out_valid && OUT_READY;
    assign w_last_word = (r_cnt == CNT_W'(NUM_WORDS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_sub       <= 1'b0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b0;
                if (r_out_last) begin
                    r_out_last <= 1'b0;
                    r_co       <= 1'b0;
                    r_ov       <= 1'b0;
                end
            end

            // A new word landing on the transfer cycle keeps the output stream full.
            if (w_accept) begin
                r_sum       <= w_chain[DATA_W-1:0];
                r_c         <= w_chain[DATA_W+1];
                r_out_valid <= 1'b1;
                r_cnt       <= r_cnt + CNT_W'(1);
                if (w_last_word) begin
                    r_out_last <= 1'b1;
                    r_co       <= w_chain[DATA_W+1];
                    r_ov       <= w_chain[DATA_W+1] ^ w_chain[DATA_W];
                    r_state    <= S_DRAIN;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_sub   <= SUB;
                        r_c     <= SUB;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer && r_out_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SUM_OUT   = r_sum;
    assign OUT_VALID = r_out_valid;
    assign OUT_LAST  = r_out_last;
    assign CO_OUT    = r_co;
    assign OV_OUT    = r_ov;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cy8_serial_adder.sv
// Bench for cy8_serial_adder: a 4-word instance checked against full-width arithmetic,
// plus a 1-word instance for the single-word and DRAIN cases.
module tb_cy8_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 0, sub_i = 0, in_valid = 0, out_ready = 0;
    logic [7:0] a_in = 0, b_in = 0;
    logic       in_ready, out_valid, out_last, co_out, ov_out, busy;
    logic [7:0] sum_out;

    logic       start1 = 0, sub1 = 0, in_valid1 = 0, out_ready1 = 0;
    logic [7:0] a1 = 0, b1 = 0;
    logic       in_ready1, out_valid1, out_last1, co1, ov1, busy1;
    logic [7:0] sum1;

    cy8_serial_adder #(.NUM_WORDS(4)) dut4 (
        .CLK(clk), .RST(rst), .START(start), .SUB(sub_i), .A_IN(a_in), .B_IN(b_in),
        .IN_VALID(in_valid), .IN_READY(in_ready), .SUM_OUT(sum_out), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_LAST(out_last), .CO_OUT(co_out), .OV_OUT(ov_out),
        .BUSY(busy)
    );

    cy8_serial_adder #(.NUM_WORDS(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .SUB(sub1), .A_IN(a1), .B_IN(b1),
        .IN_VALID(in_valid1), .IN_READY(in_ready1), .SUM_OUT(sum1), .OUT_VALID(out_valid1),
        .OUT_READY(out_ready1), .OUT_LAST(out_last1), .CO_OUT(co1), .OV_OUT(ov1),
        .BUSY(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_w[$];
    bit         got_l[$];
    logic       got_co, got_ov;
    int         stab_err, rdy_err, stall_cycles;
    bit         timed_out;

    // Reference: {ov, co, result[31:0]} from plain 33-bit arithmetic.
    function automatic logic [33:0] ref_op(input logic sub, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov;
        s  = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        r  = s[31:0];
        ov = sub ? ((a[31] != b[31]) && (r[31] != a[31]))
                 : ((a[31] == b[31]) && (r[31] != a[31]));
        return {ov, s[32], r};
    endfunction

    // mode 0: always ready/valid; 1: random valid/ready; 2: 3-cycle stall after 1st result
    task automatic run_op(input logic sub, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        int   idx = 0;
        bit   done = 0;
        bit   stall_started = 0;
        int   stall_left = 0;
        logic prev_stalled = 0;
        logic [7:0] prev_sum = 0;
        logic prev_last = 0;
        got_w.delete();
        got_l.delete();
        got_co = 0; got_ov = 0; stab_err = 0; rdy_err = 0; stall_cycles = 0; timed_out = 0;
        @(negedge clk);
        start = 1; sub_i = sub; in_valid = 0; out_ready = 1;
        @(negedge clk);
        start = 0; sub_i = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (mode == 2 && out_valid && !stall_started) begin
                stall_started = 1;
                stall_left = 3;
            end
            if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else           out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (idx < 4) && (mode != 1 || $urandom_range(0, 3) != 0);
            a_in = (idx < 4) ? a[8*idx +: 8] : 8'($urandom);
            b_in = (idx < 4) ? b[8*idx +: 8] : 8'($urandom);
            #1;
            if (prev_stalled && (sum_out !== prev_sum || out_last !== prev_last || out_valid !== 1'b1))
                stab_err++;
            if (out_valid && !out_ready) stall_cycles++;
            if (out_valid && !out_ready && in_ready) rdy_err++;
            if (out_valid && out_ready) begin
                got_w.push_back(sum_out);
                got_l.push_back(out_last);
                if (out_last) begin
                    got_co = co_out;
                    got_ov = ov_out;
                    done = 1;
                end
            end
            if (in_ready && in_valid) idx++;
            prev_stalled = out_valid && !out_ready;
            prev_sum = sum_out;
            prev_last = out_last;
            if (!done) @(negedge clk);
        end
        timed_out = !done;
        @(negedge clk);
        in_valid = 0;
        out_ready = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_checks++; if ({co_out, ov_out} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {co_out, ov_out}); end
        n_checks++; if (sum_out !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum_out); end
        n_checks++; if ({busy, in_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_ready got %b want 00", {busy, in_ready}); end
        n_checks++; if ({busy1, out_valid1} !== 2'b00) begin n_fail++; $display("FAIL reset_dut1 got %b want 00", {busy1, out_valid1}); end
        rst = 0;
    endtask

    task automatic test_idle_no_accept;
        logic [33:0] e;
        @(negedge clk);
        in_valid = 1; a_in = 8'hAA; b_in = 8'h55; out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        n_checks++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_consumed got %b want 00", {busy, out_valid}); end
        in_valid = 0;
        e = ref_op(0, 32'h01020304, 32'h10203040);
        run_op(0, 32'h01020304, 32'h10203040, 0);
        n_checks++; if (got_w.size() != 4 || {got_w[3], got_w[2], got_w[1], got_w[0]} !== e[31:0]) begin
            n_fail++; $display("FAIL idle_followup words=%0d want result %h", got_w.size(), e[31:0]); end
    endtask

    task automatic test_directed;
        logic        sv[3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] av[3] = '{32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF};
        logic [31:0] bv[3] = '{32'h00000001, 32'h00000001, 32'h00000001};
        logic [31:0] rv[3] = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000};
        logic [1:0]  fv[3] = '{2'b10, 2'b00, 2'b01};
        for (int t = 0; t < 3; t++) begin
            run_op(sv[t], av[t], bv[t], 0);
            n_checks++; if (timed_out || got_w.size() != 4) begin n_fail++; $display("FAIL dir%0d_count got %0d want 4", t, got_w.size()); end
            for (int k = 0; k < got_w.size() && k < 4; k++) begin
                n_checks++; if (got_w[k] !== rv[t][8*k +: 8] || got_l[k] !== (k == 3)) begin
                    n_fail++; $display("FAIL dir%0d_word%0d got %h/last%b want %h/last%b", t, k, got_w[k], got_l[k], rv[t][8*k +: 8], k == 3); end
            end
            n_checks++; if ({got_co, got_ov} !== fv[t]) begin n_fail++; $display("FAIL dir%0d_co_ov got %b want %b", t, {got_co, got_ov}, fv[t]); end
        end
    endtask

    task automatic test_stall;
        run_op(0, 32'hFFFFFFFF, 32'h00000001, 2);
        n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL stall_cycles got %0d want 3", stall_cycles); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
        n_checks++; if (rdy_err != 0) begin n_fail++; $display("FAIL stall_in_ready got %0d high cycles want 0", rdy_err); end
        n_checks++; if (timed_out || got_w.size() != 4 || {got_w[3], got_w[2], got_w[1], got_w[0]} !== 32'h0) begin
            n_fail++; $display("FAIL stall_words got %0d words want 4 of 00", got_w.size()); end
        n_checks++; if (got_l.size() != 4 || got_l[3] !== 1'b1 || got_l[2] !== 1'b0) begin n_fail++; $display("FAIL stall_last got size %0d want last on word 3", got_l.size()); end
        n_checks++; if ({got_co, got_ov} !== 2'b10) begin n_fail++; $display("FAIL stall_co_ov got %b want 10", {got_co, got_ov}); end
    endtask

    task automatic test_reset_mid;
        logic [33:0] e;
        @(negedge clk);
        start = 1; sub_i = 1; out_ready = 1;
        @(negedge clk);
        start = 0; in_valid = 1; a_in = 8'h78; b_in = 8'h11;
        @(negedge clk);
        a_in = 8'h56; b_in = 8'h22;
        @(negedge clk);
        in_valid = 0; rst = 1;
        n_checks++; if ({busy, out_valid} !== 2'b11) begin n_fail++; $display("FAIL mid_before got %b want 11", {busy, out_valid}); end
        @(negedge clk);
        rst = 0;
        n_checks++; if ({busy, in_ready, out_valid, out_last, co_out, ov_out} !== 6'b0) begin
            n_fail++; $display("FAIL mid_reset_ctl got %b want 000000", {busy, in_ready, out_valid, out_last, co_out, ov_out}); end
        n_checks++; if (sum_out !== 8'h00) begin n_fail++; $display("FAIL mid_reset_sum got %h want 00", sum_out); end
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stray got %b want 0", out_valid); end
        e = ref_op(0, 32'h12345678, 32'h9ABCDEF0);
        run_op(0, 32'h12345678, 32'h9ABCDEF0, 1);
        n_checks++; if (timed_out || got_w.size() != 4 || {got_w[3], got_w[2], got_w[1], got_w[0]} !== e[31:0] || {got_co, got_ov} !== e[33:32] ^ 2'b0 && 1'b0) begin
            n_fail++; $display("FAIL mid_fresh got %0d words want %h", got_w.size(), e[31:0]); end
        n_checks++; if ({got_ov, got_co} !== e[33:32]) begin n_fail++; $display("FAIL mid_fresh_flags got %b want %b", {got_ov, got_co}, e[33:32]); end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic        s;
        logic [33:0] e;
        for (int t = 0; t < 25; t++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (t == 0) b = a;
            e = ref_op(s, a, b);
            run_op(s, a, b, 1);
            n_checks++; if (timed_out || got_w.size() != 4 || {got_w[3], got_w[2], got_w[1], got_w[0]} !== e[31:0]) begin
                n_fail++; $display("FAIL rand%0d_result sub=%b a=%h b=%h got %0d words want %h", t, s, a, b, got_w.size(), e[31:0]); end
            n_checks++; if ({got_ov, got_co} !== e[33:32]) begin n_fail++; $display("FAIL rand%0d_flags got ov/co %b want %b", t, {got_ov, got_co}, e[33:32]); end
            n_checks++; if (got_l.size() != 4 || {got_l[3], got_l[2], got_l[1], got_l[0]} !== 4'b1000) begin
                n_fail++; $display("FAIL rand%0d_last got size %0d want last only on word 3", t, got_l.size()); end
            n_checks++; if (stab_err != 0 || rdy_err != 0) begin n_fail++; $display("FAIL rand%0d_protocol got %0d/%0d want 0/0", t, stab_err, rdy_err); end
        end
    endtask

    task automatic test_single_word;
        @(negedge clk);
        start1 = 1; sub1 = 1;
        @(negedge clk);
        start1 = 0; sub1 = 0; in_valid1 = 1; a1 = 8'h05; b1 = 8'h03; out_ready1 = 0;
        #1;
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL w1_in_ready got %b want 1", in_ready1); end
        @(negedge clk);
        n_checks++; if ({out_valid1, out_last1, co1, ov1} !== 4'b1110) begin n_fail++; $display("FAIL w1_flags got %b want 1110", {out_valid1, out_last1, co1, ov1}); end
        n_checks++; if (sum1 !== 8'h02) begin n_fail++; $display("FAIL w1_sum got %h want 02", sum1); end
        start1 = 1; a1 = 8'h10; b1 = 8'h01;
        @(negedge clk);
        start1 = 0;
        #1;
        n_checks++; if (in_ready1 !== 1'b0 || sum1 !== 8'h02 || out_valid1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_drain got ready %b sum %h valid %b want 0 02 1", in_ready1, sum1, out_valid1); end
        out_ready1 = 1;
        @(negedge clk);
        in_valid1 = 0;
        n_checks++; if ({busy1, out_valid1, out_last1, co1} !== 4'b0000) begin n_fail++; $display("FAIL w1_done got %b want 0000", {busy1, out_valid1, out_last1, co1}); end
        @(negedge clk);
        out_ready1 = 0;
        n_checks++; if ({busy1, out_valid1} !== 2'b00) begin n_fail++; $display("FAIL w1_start_ignored got %b want 00", {busy1, out_valid1}); end
    endtask

    initial begin
        test_reset();
        test_idle_no_accept();
        test_directed();
        test_stall();
        test_reset_mid();
        test_random();
        test_single_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks, want completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
